// File: rtl/reload_down_counter_pkg.sv
// Shared definitions for the reload down-counter: FSM state encoding and the
// default counter width.
package reload_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/reload_down_counter.sv
// Loadable down-counter with one-shot / periodic (auto-reload) modes.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   load         synchronous load strobe (highest priority after reset)
//   data         start / reload value, sampled when load=1
//   en           count enable, honoured only in RUN
//   auto_reload  1 = periodic, 0 = one-shot
//   count        registered current count
//   tc           registered one-cycle terminal-count pulse
//   busy         state is RUN
//   done         state is DONE
//   zero         combinational (count == 0)
module reload_down_counter
  import reload_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic [WIDTH-1:0] count_n;
  logic             tc_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      tc         <= tc_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    tc_n     = 1'b0;
    if (load) begin
      count_n  = data;
      reload_n = data;
      // Loading zero has nothing to count, so park in IDLE.
      state_n  = (data != '0) ? RUN : IDLE;
    end else if (state == RUN && en) begin
      if (count > ONE) begin
        count_n = count - ONE;
      end else if (count == ONE) begin
        tc_n = 1'b1;
        if (auto_reload) begin
          count_n = reload_reg;
        end else begin
          count_n = '0;
          state_n = DONE;
        end
      end
      // count==0 in RUN cannot be reached; holding there prevents any wrap.
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign zero = (count == '0);

endmodule
